// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I single-cycle core front end.
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/npc_calc.sv
// Next-PC selection: sequential, pc-relative or register (jalr) target.
module npc_calc
  import core_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_c,
  input  logic            npc_op,
  input  logic            jalr,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);
  logic [XLEN-1:0] tgt;

  // jalr clears bit 0 only; bit 1 may still be set and is caught as misaligned
  assign tgt      = jalr ? (alu_c & ~32'h1) : (pc + imm);
  assign next_pc  = npc_op ? tgt : (pc + 32'd4);
  assign misalign = |next_pc[1:0];
endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: owns the PC, handshakes with imem, presents one instruction
// per execute cycle and retires it on the EXEC exit edge.
module pc_fetch
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            npc_op,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_c,
  input  logic            exec_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic            inst_valid,
  output logic [XLEN-1:0] instret,
  output logic            misalign
);
  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q, inst_q, instret_q;
  logic            req_q, vld_q, mis_q;
  logic [XLEN-1:0] next_pc;
  logic            npc_mis;

  npc_calc u_npc (
    .pc      (pc_q),
    .imm     (imm),
    .alu_c   (alu_c),
    .npc_op  (npc_op),
    .jalr    (jalr),
    .next_pc (next_pc),
    .misalign(npc_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      instret_q <= '0;
      req_q     <= 1'b0;
      vld_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: if (imem_ack) begin
          inst_q  <= imem_rdata;
          state_q <= EXEC;
          req_q   <= 1'b0;
          vld_q   <= 1'b1;
        end
        EXEC: if (!exec_stall) begin
          // a misaligned target still retires and lands in pc for debug
          pc_q      <= next_pc;
          instret_q <= instret_q + 32'd1;
          vld_q     <= 1'b0;
          if (npc_mis) begin
            mis_q   <= 1'b1;
            state_q <= HALT;
          end else begin
            req_q   <= 1'b1;
            state_q <= FETCH;
          end
        end
        HALT: begin
          req_q <= 1'b0;
          vld_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign pc         = pc_q;
  assign pc4        = pc_q + 32'd4;
  assign inst_valid = vld_q;
  assign instret    = instret_q;
  assign misalign   = mis_q;
endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with a hand-driven instruction memory.
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        npc_op, jalr, exec_stall, imem_ack;
  logic [31:0] imm, alu_c, imem_rdata;
  logic        imem_req, inst_valid, misalign;
  logic [31:0] imem_addr, inst, pc, pc4, instret;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int c0;

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .npc_op(npc_op), .jalr(jalr), .imm(imm),
    .alu_c(alu_c), .exec_stall(exec_stall), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .pc(pc), .pc4(pc4), .inst_valid(inst_valid),
    .instret(instret), .misalign(misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expects to be in FETCH; acks on the lat-th cycle and leaves the DUT in EXEC.
  task automatic do_fetch(input int lat, input logic [31:0] word, input logic [31:0] epc);
    chk("fetch_req", {31'b0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, epc);
    for (int i = 1; i < lat; i++) begin
      imem_ack = 1'b0;
      step();
      chk("req_hold", {31'b0, imem_req}, 32'd1);
      chk("fetch_vld", {31'b0, inst_valid}, 32'd0);
      chk("fetch_pc", pc, epc);
    end
    imem_ack = 1'b1; imem_rdata = word;
    step();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    chk("exec_vld", {31'b0, inst_valid}, 32'd1);
    chk("exec_inst", inst, word);
    chk("exec_req", {31'b0, imem_req}, 32'd0);
    chk("exec_pc", pc, epc);
    chk("exec_pc4", pc4, epc + 32'd4);
  endtask

  task automatic do_exec(input int stalls, input logic [31:0] word, input logic [31:0] epc,
                         input logic op, input logic jr, input logic [31:0] im,
                         input logic [31:0] ac);
    for (int i = 0; i < stalls; i++) begin
      exec_stall = 1'b1;
      step();
      chk("stall_pc", pc, epc);
      chk("stall_inst", inst, word);
      chk("stall_vld", {31'b0, inst_valid}, 32'd1);
    end
    exec_stall = 1'b0; npc_op = op; jalr = jr; imm = im; alu_c = ac;
    step();
    npc_op = 1'b0; jalr = 1'b0; imm = 32'h0; alu_c = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0; npc_op = 1'b0; jalr = 1'b0; exec_stall = 1'b0;
    imem_ack = 1'b0; imm = 32'h0; alu_c = 32'h0; imem_rdata = 32'h0;
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_vld", {31'b0, inst_valid}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_mis", {31'b0, misalign}, 32'd0);
    rst_n = 1'b1;

    // IDLE lasts one cycle, then sequential zero-wait fetches
    step();
    c0 = cyc;
    do_fetch(1, 32'h0010_0093, 32'h00); do_exec(0, 32'h0010_0093, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    do_fetch(1, 32'h0020_0113, 32'h04); do_exec(0, 32'h0020_0113, 32'h04, 1'b0, 1'b0, 32'h0, 32'h0);
    do_fetch(1, 32'h0030_0193, 32'h08); do_exec(0, 32'h0030_0193, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("seq_cycles", cyc - c0, 32'd6);
    chk("seq_instret", instret, 32'd3);
    chk("seq_pc", pc, 32'h0C);

    do_fetch(1, 32'h0040_0213, 32'h0C); do_exec(0, 32'h0040_0213, 32'h0C, 1'b0, 1'b0, 32'h0, 32'h0);
    // branch back by 8 from 0x10; alu_c is junk and must be ignored
    do_fetch(1, 32'hFE00_0CE3, 32'h10);
    do_exec(0, 32'hFE00_0CE3, 32'h10, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0000_0555);
    chk("br_addr", imem_addr, 32'h08);
    chk("br_instret", instret, 32'd5);

    // latency 3 plus two stall cycles, with stray acks ignored during EXEC
    c0 = cyc;
    do_fetch(3, 32'h0050_0293, 32'h08);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    do_exec(2, 32'h0050_0293, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0);
    imem_ack = 1'b0;
    chk("lat_cycles", cyc - c0, 32'd6);
    chk("lat_instret", instret, 32'd6);
    chk("lat_pc", pc, 32'h0C);

    // jalr to 0x103 -> 0x102, misaligned, halts
    do_fetch(1, 32'h0000_80E7, 32'h0C);
    do_exec(0, 32'h0000_80E7, 32'h0C, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0103);
    chk("jalr_pc", pc, 32'h0000_0102);
    chk("jalr_mis", {31'b0, misalign}, 32'd1);
    chk("jalr_instret", instret, 32'd7);
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("halt_req", {31'b0, imem_req}, 32'd0);
      chk("halt_vld", {31'b0, inst_valid}, 32'd0);
      chk("halt_pc", pc, 32'h0000_0102);
      step();
    end
    chk("halt_instret", instret, 32'd7);
    imem_ack = 1'b0;

    // reset pulse in FETCH while ack is up
    rst_n = 1'b0; #2; rst_n = 1'b1;
    chk("hrst_mis", {31'b0, misalign}, 32'd0);
    step();
    do_fetch(1, 32'h0060_0313, 32'h00); do_exec(0, 32'h0060_0313, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("pre_instret", instret, 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    #2; rst_n = 1'b0; #1;
    chk("mrst_pc", pc, 32'h0);
    chk("mrst_inst", inst, 32'h0000_0013);
    chk("mrst_instret", instret, 32'd0);
    chk("mrst_vld", {31'b0, inst_valid}, 32'd0);
    step();
    rst_n = 1'b1; imem_ack = 1'b0;
    chk("mrst_idle_req", {31'b0, imem_req}, 32'd0);
    step();
    do_fetch(1, 32'h0070_0393, 32'h00);
    chk("mrst_end_instret", instret, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch stage of the single-cycle RV32I core, directly upstream of the control decoder. Holds the architectural PC and fetches each instruction from a variable-latency instruction memory over a req/ack handshake. Presents the instruction to the decoder for exactly one execute cycle. Computes the next PC from the decoder's `npc_op` and the ALU/immediate results produced during that cycle.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset; must be word-aligned.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `npc_op` input 1: from control; 1 = take the computed target, 0 = pc+4.
- `jalr` input 1: when `npc_op`=1, selects the register target (`alu_c`) instead of pc+`imm`.
- `imm` input 32: sign-extended immediate from `sext`.
- `alu_c` input 32: ALU result, which is the jalr target.
- `exec_stall` input 1: holds the current instruction in EXEC (data memory busy).
- `imem_req` output 1: fetch request.
- `imem_addr` output 32: fetch address; equals `pc`.
- `imem_ack` input 1: read data valid this cycle.
- `imem_rdata` input 32: instruction word.
- `inst` output 32: registered instruction to the decoder.
- `pc` output 32: current PC.
- `pc4` output 32: `pc`+4, used for the jal/jalr writeback.
- `inst_valid` output 1: high in the execute cycle; the register file and DRAM write enables are gated with it.
- `instret` output 32: count of retired instructions.
- `misalign` output 1: sticky; set when a taken target has bits [1:0] ≠ 0.

## Operation
- FSM states: IDLE, FETCH, EXEC, HALT.
- IDLE: entered on reset; moves to FETCH unconditionally after 1 cycle.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_ack`, register `imem_rdata` into `inst`, then go to EXEC.
  - `imem_req` stays high until ack.
  - `pc` is not changed in this state.
- EXEC: `inst_valid`=1, `imem_req`=0.
  - If `exec_stall`=1, remain in EXEC; `pc` and `inst` hold.
  - Otherwise, at the clock edge:
    - `pc` ← next_pc.
    - `instret` increments.
    - Go to FETCH.
- next_pc, all arithmetic 32-bit and wrapping modulo 2^32:
  - `npc_op`=0: `pc`+4.
  - `npc_op`=1, `jalr`=0: `pc`+`imm`.
  - `npc_op`=1, `jalr`=1: `alu_c` & ~32'h1.
- Misalignment:
  - Check applies when next_pc[1:0] ≠ 0 at the EXEC exit edge.
  - On that edge: `misalign` ← 1, `pc` ← next_pc (for debug), `instret` still increments, go to HALT.
- HALT:
  - `imem_req`=0 and `inst_valid`=0 permanently.
  - Only reset leaves HALT.
- `imem_ack` outside FETCH is ignored.
- `instret` wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `inst`=32'h0000_0013 (nop).
  - `inst_valid`=0, `imem_req`=0, `instret`=0, `misalign`=0.
  - State = IDLE.
- Reset asserted mid-FETCH or mid-EXEC:
  - All state returns to reset values immediately.
  - An in-flight ack is dropped; no retire is counted.
- Zero-wait memory (ack in the first FETCH cycle): 2 cycles per instruction.
  - Cycle n: FETCH; cycle n+1: EXEC.
- A memory latency of L ack cycles gives L+1 cycles per instruction; each stall cycle adds 1.
- `inst`, `pc` and `pc4` are stable throughout EXEC. `npc_op`, `imm` and `alu_c` are sampled only at the EXEC exit edge.
- `pc4` is combinational from `pc`.

## Structure
- Shared package `core_pkg`:
  - `fetch_state_t` enum: IDLE, FETCH, EXEC, HALT.
  - `NOP_INST` = 32'h0000_0013.
  - `XLEN` = 32.
- Sub-module `npc_calc`: combinational next-PC mux and adders.
  - Inputs: `pc`, `imm`, `alu_c`, `npc_op`, `jalr`.
  - Outputs: `next_pc`, `misalign`.
  - Instantiated once.

## Test plan
- Reset release, zero-wait memory, all `npc_op`=0:
  - `imem_addr` sequence 0, 4, 8 with EXEC every second cycle.
  - `instret`=3 after the third EXEC.
- Branch taken at `pc`=32'h10 with `npc_op`=1, `jalr`=0, `imm`=32'hFFFF_FFF8:
  - next fetch address is 32'h08.
- jalr with `alu_c`=32'h0000_0103:
  - next `pc`=32'h0000_0102.
  - `misalign`=1, FSM in HALT, `imem_req` stays 0.
- Memory latency 3 plus `exec_stall` held for 2 cycles:
  - 6 cycles per instruction.
  - `inst` and `pc` unchanged during the stall; `instret` increments once.
- `rst_n` pulsed low during FETCH while `imem_ack` is asserted:
  - `pc`=`RESET_PC`, `inst`=32'h0000_0013, `instret`=0.
  - Fetch restarts after one IDLE cycle.
